pattern_scan_engine: RTL
========================

# pattern_scan_engine

Sequential, parametrised successor to the combinational comma-code locator. It latches a WORD_SIZE-bit word on a start request and scans it one bit per clock, LSB first, for a PAT_LEN-bit pattern. It reports whether the pattern occurs, the bit index of its first occurrence and the number of occurrences, with overlapping or non-overlapping counting selectable at run time. It sits between a word source and a controller, using a start/busy/done handshake.

## Interface
- WORD_SIZE, 16, width of the scanned word
- INDEX_SIZE, 4, index width; 2**INDEX_SIZE >= WORD_SIZE
- PAT_LEN, 3, pattern length; 1 <= PAT_LEN <= WORD_SIZE
- PATTERN, 3'b101, pattern bits; PATTERN[PAT_LEN-1] is matched against the highest bit of the window
- trigger  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  scan request, sampled only in IDLE
- overlap  input  1  1 = overlapping matches counted; sampled with start
- word_in  input  WORD_SIZE  word to scan; sampled with start
- busy  output  1  high while a scan is in progress
- done  output  1  one-cycle pulse; results valid
- found  output  1  at least one match
- first_index  output  INDEX_SIZE  lowest bit index of the first match
- match_count  output  INDEX_SIZE+1  number of matches

## Operation
- States are IDLE, SCAN and DONE.
- **IDLE:** busy=0. If start=1 at an edge:
  - latch word_in and overlap;
  - clear found, first_index, match_count, pos and fill;
  - go to SCAN.
- **SCAN:** busy=1. Each edge shifts word[pos] into the top of a PAT_LEN-bit window and sets fill = min(fill+1, PAT_LEN).
- **Match rule:** a match occurs when fill reaches PAT_LEN and window == PATTERN, i.e. word[pos -: PAT_LEN] == PATTERN.
  - On the first match: found=1 and first_index = pos-PAT_LEN+1.
  - match_count increments on every match.
  - In non-overlap mode, fill clears to 0 after a match, so the next match uses only fresh bits.
- **End of scan:** after the edge that processes pos = WORD_SIZE-1, go to DONE.
- **DONE:** done=1 and busy=0 for exactly one cycle, then IDLE.
- **Result hold:** found, first_index and match_count hold until the next accepted start.
- **Ignored starts:** start is ignored in SCAN and DONE; no queueing.
- **No match:** found=0, first_index=0, match_count=0.
- **Count width:** match_count never exceeds WORD_SIZE-PAT_LEN+1, so INDEX_SIZE+1 bits cannot overflow.
- **Reset mid-operation:** returns to IDLE immediately; all outputs are cleared and the partial scan is discarded.

## Timing
- Reset values: state=IDLE, busy=0, done=0, found=0, first_index=0, match_count=0.
- All outputs are registered.
- Start accepted at edge E0 → busy=1 after E0.
- Bit p is processed at edge E(p+1).
- DONE is entered after E(WORD_SIZE): done is high in the cycle after that edge, and busy falls at the same edge.
- Total latency from start edge to done is WORD_SIZE+1 cycles.
- The earliest next start is accepted one cycle after done, i.e. in IDLE.
- word_in and overlap may change freely after E0.

## Configuration
- **SCAN_EARLY_EXIT_EN defined:** SCAN moves to DONE at the edge that detects the first match.
  - done follows that edge.
  - match_count is at most 1.
  - Latency is first_index+PAT_LEN+1 cycles on a hit, and WORD_SIZE+1 on a miss.
- **Undefined:** a full WORD_SIZE-bit scan always runs, as described in Operation.

## Test plan
- **Single hit:** word_in=16'h0005, overlap=1, start pulse → done exactly 17 cycles after the start edge; found=1, first_index=0, match_count=1.
- **Mode comparison:** word_in=16'h0AA0.
  - overlap=1 → found=1, first_index=5, match_count=3.
  - Rerun with overlap=0 → first_index=5, match_count=2.
- **Misses:**
  - word_in=16'h0000 → found=0, first_index=0, match_count=0.
  - word_in=16'hFFFF → found=0, match_count=0.
- **Ignored start:** word_in=16'h0AA0, start, then start with word_in=16'h0000 held high through busy → second request ignored; results match the first word (count 3); busy stays high for 16 cycles.
- **Reset mid-scan:** reset pulsed 8 cycles into a scan of 16'h0AA0 → all outputs 0 immediately, with no done pulse. A following start on 16'h0005 completes normally with match_count=1.
- **Early exit (SCAN_EARLY_EXIT_EN defined):** word_in=16'h0AA0 → done 9 cycles after the start edge; first_index=5, match_count=1. With the macro undefined, done comes after 17 cycles.

Source files
------------

// File: rtl/pattern_scan_engine_if.sv
// Handshake and result bundle between a controller (master) and pattern_scan_engine (slave).
// Widths follow the engine's WORD_SIZE / INDEX_SIZE parameters.
interface pattern_scan_engine_if #(
   parameter int unsigned WORD_SIZE  = 16,
   parameter int unsigned INDEX_SIZE = 4
);
   logic                  start;
   logic                  overlap;
   logic [WORD_SIZE-1:0]  word_in;
   logic                  busy;
   logic                  done;
   logic                  found;
   logic [INDEX_SIZE-1:0] first_index;
   logic [INDEX_SIZE:0]   match_count;

   modport master (
      output start, overlap, word_in,
      input  busy, done, found, first_index, match_count
   );

   modport slave (
      input  start, overlap, word_in,
      output busy, done, found, first_index, match_count
   );
endinterface

// File: rtl/pattern_scan_engine.sv
// Bit-serial scanner: finds PATTERN in a latched word, LSB first, one bit per clock.
// Optional macro SCAN_EARLY_EXIT_EN ends the scan at the first match.
module pattern_scan_engine #(
   parameter int unsigned         WORD_SIZE  = 16,
   parameter int unsigned         INDEX_SIZE = 4,
   parameter int unsigned         PAT_LEN    = 3,
   parameter logic [PAT_LEN-1:0]  PATTERN    = 3'b101
) (
   input logic                    trigger,
   input logic                    reset,
   pattern_scan_engine_if.slave   bus
);

   localparam int unsigned           FillW    = $clog2(PAT_LEN + 1);
   localparam logic [FillW-1:0]      FillFull = FillW'(PAT_LEN);
   localparam logic [INDEX_SIZE-1:0] LastPos  = INDEX_SIZE'(WORD_SIZE - 1);
   localparam logic [INDEX_SIZE-1:0] PatOff   = INDEX_SIZE'(PAT_LEN - 1);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e                state_q, state_d;
   logic [WORD_SIZE-1:0]  word_q, word_d;
   logic                  overlap_q, overlap_d;
   logic [INDEX_SIZE-1:0] pos_q, pos_d;
   logic [FillW-1:0]      fill_q, fill_d;
   logic [PAT_LEN-1:0]    window_q, window_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  found_q, found_d;
   logic [INDEX_SIZE-1:0] first_index_q, first_index_d;
   logic [INDEX_SIZE:0]   match_count_q, match_count_d;

   logic [PAT_LEN-1:0]    window_adv;
   logic [FillW-1:0]      fill_adv;
   logic                  hit;
   logic                  last;

   always_comb begin
      state_d       = state_q;
      word_d        = word_q;
      overlap_d     = overlap_q;
      pos_d         = pos_q;
      fill_d        = fill_q;
      window_d      = window_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      found_d       = found_q;
      first_index_d = first_index_q;
      match_count_d = match_count_q;

      // Newest bit enters at the top, so the window reads word[pos -: PAT_LEN].
      window_adv              = window_q >> 1;
      window_adv[PAT_LEN-1]   = word_q[pos_q];
      fill_adv                = (fill_q == FillFull) ? fill_q : fill_q + 1'b1;
      hit                     = (fill_adv == FillFull) && (window_adv == PATTERN);
      last                    = (pos_q == LastPos);
`ifdef SCAN_EARLY_EXIT_EN
      if (hit) begin
         last = 1'b1;
      end
`endif

      case (state_q)
         StIdle: begin
            busy_d = 1'b0;
            if (bus.start) begin
               word_d        = bus.word_in;
               overlap_d     = bus.overlap;
               found_d       = 1'b0;
               first_index_d = '0;
               match_count_d = '0;
               pos_d         = '0;
               fill_d        = '0;
               window_d      = '0;
               busy_d        = 1'b1;
               state_d       = StScan;
            end
         end

         StScan: begin
            window_d = window_adv;
            fill_d   = fill_adv;
            pos_d    = pos_q + 1'b1;
            if (hit) begin
               if (!found_q) begin
                  found_d       = 1'b1;
                  first_index_d = pos_q - PatOff;
               end
               match_count_d = match_count_q + 1'b1;
               // Non-overlap: next match must be built only from bits after this one.
               if (!overlap_q) begin
                  fill_d = '0;
               end
            end
            if (last) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = StDone;
            end
         end

         StDone: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge trigger or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         word_q        <= '0;
         overlap_q     <= 1'b0;
         pos_q         <= '0;
         fill_q        <= '0;
         window_q      <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         found_q       <= 1'b0;
         first_index_q <= '0;
         match_count_q <= '0;
      end else begin
         state_q       <= state_d;
         word_q        <= word_d;
         overlap_q     <= overlap_d;
         pos_q         <= pos_d;
         fill_q        <= fill_d;
         window_q      <= window_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         found_q       <= found_d;
         first_index_q <= first_index_d;
         match_count_q <= match_count_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.found       = found_q;
   assign bus.first_index = first_index_q;
   assign bus.match_count = match_count_q;

endmodule
